ifu_prefetch: RTL and testbench
===============================

Name: ifu_prefetch

Overview:
Instruction fetch/prefetch unit upstream of the decode/GPR/ALU datapath. It replaces the bare pc+4 register and combinational IM lookup with a handshaked fetch from a variable-latency instruction memory. Fetched instructions are buffered in a small FIFO so decode sees a steady valid/ready stream. It accepts a redirect (branch/jump target) that flushes buffered and in-flight instructions.

Parameters:
DEPTH, 4, FIFO entries (power of 2, ≥2)
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
mem_req  output  1  fetch request to instruction memory
mem_addr  output  32  fetch address, word aligned (bits[1:0]=0)
mem_gnt  input  1  memory accepts request this cycle
mem_rvalid  input  1  fetch data valid
mem_rdata  input  32  fetched instruction
redirect  input  1  flush and restart fetch at redirect_pc
redirect_pc  input  32  new fetch address; bits[1:0] ignored (forced 0)
out_valid  output  1  instruction available to decode
out_ready  input  1  decode accepts instruction
out_instr  output  32  instruction at FIFO head
out_pc  output  32  address of out_instr
fifo_count  output  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (reset=0, async): fetch_pc=RESET_PC, state=IDLE, FIFO empty, discard=0. Outputs mem_req=0, mem_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=0, fifo_count=0.
- FSM states: IDLE, REQ (mem_req=1), WAIT (granted, awaiting rvalid). At most one request in flight.
- IDLE→REQ when fifo_count<DEPTH. The first cycle after reset release has mem_req=1.
- REQ: mem_req and mem_addr are held stable until mem_gnt. On gnt: fetch_pc+=4 (wraps 32'hFFFF_FFFC→0), latch req_pc=mem_addr, →WAIT.
- WAIT: memory guarantees rvalid ≥1 cycle after gnt. On rvalid: push {req_pc, mem_rdata} unless discard=1, then clear discard. Next state is REQ if post-push count<DEPTH, else IDLE.
- Room reservation: a request is issued only when count<DEPTH, so a returning word always has a free slot. Response data is never dropped for lack of space.
- Output: out_valid = FIFO non-empty. out_instr/out_pc come from the head register (registered, no comb path from mem_rdata). Pop on out_valid&out_ready.
- Latency: rvalid in cycle N → out_valid in cycle N+1. Peak throughput is 1 instr per 2 cycles with a 1-cycle memory.
- Simultaneous push+pop when full: both occur and count stays DEPTH. Push+pop on empty is not possible because out_valid=0 that cycle.
- Redirect (cycle N, takes priority):
  - Any out_valid&out_ready transfer in cycle N still completes.
  - At edge N: FIFO flushed (count=0) and fetch_pc=redirect_pc&~3.
  - If state=IDLE → REQ with mem_addr=redirect_pc in cycle N+1.
  - If state=REQ and not granted in N: the request stays asserted with its old address (stability rule). It is marked discard=1 at grant, and fetch restarts at redirect_pc afterwards.
  - If REQ with gnt in N: →WAIT with discard=1.
  - If state=WAIT: discard=1, and a response arriving in cycle N itself is also dropped.
  - Redirect simultaneous with rvalid: data dropped, then REQ at redirect_pc.
  - Back-to-back redirects: the last one wins.
- fetch_pc is separate from mem_addr during REQ-hold-after-redirect. mem_addr = pending address while in REQ, else fetch_pc.
- Reset mid-operation clears all state immediately. The memory side must be reset by the same reset.

Decomposition:
- Shared package cpu_pkg: INSTR_W=32, ADDR_W=32, fetch FSM enum {IDLE, REQ, WAIT}, PC_STEP=4, RESET_PC default.
- Sub-module ifu_fifo: synchronous FIFO of {pc, instr}. It has push/pop/flush and count, a registered head, and wrap-around read/write pointers with an extra bit for full/empty.

Test Plan:
- Reset then 1-cycle memory, out_ready=1 → mem_addr 0,4,8,… and out_pc/out_instr pairs match the memory image. One instr every 2 cycles; first out_valid at cycle 3 after reset release.
- out_ready=0, DEPTH=4 → exactly 4 fetches (0x0–0xC), mem_req drops, fifo_count=4. Raise out_ready → pop 0x0 and the next fetch is 0x10.
- Memory delays gnt 3 cycles → mem_req/mem_addr held stable all 3 cycles. No duplicate or missing instruction.
- redirect to 0x0000_0103 while in WAIT → in-flight word dropped, FIFO empty, next mem_addr=0x100, first out_pc=0x100.
- redirect in the same cycle as rvalid and out_valid&out_ready → head instr consumed, arriving word dropped, next fetch at redirect target.
- RESET_PC=32'hFFFF_FFF8 → addresses FFFF_FFF8, FFFF_FFFC, 0000_0000. Assert reset mid-WAIT → mem_req=0 and out_valid=0 immediately (asynchronous).

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU front-end types and constants: widths, fetch FSM states, FIFO entry layout.
package cpu_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned ADDR_W  = 32;

    localparam logic [ADDR_W-1:0] PC_STEP          = 32'd4;
    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
        return addr & ~ADDR_W'(3);
    endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous FIFO of fetched {pc, instr} pairs. The head entry is held in its own register
// so decode sees registered outputs; pointers carry an extra wrap bit for full/empty.
module ifu_fifo
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [ADDR_W-1:0]      push_pc,
    input  logic [INSTR_W-1:0]     push_instr,
    output logic [ADDR_W-1:0]      head_pc,
    output logic [INSTR_W-1:0]     head_instr,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PW        = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_CNT = (PW + 1)'(DEPTH);
    localparam logic [PW:0] ONE_CNT   = (PW + 1)'(1);

    logic [PW:0]   wr_ptr_q, wr_ptr_d;
    logic [PW:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] rd_next_idx;
    logic          do_push, do_pop;
    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  head_q, head_d;
    fetch_entry_t  push_entry;

    assign push_entry  = '{pc: push_pc, instr: push_instr};
    assign count       = wr_ptr_q - rd_ptr_q;
    assign empty       = (count == '0);
    assign full        = (count == DEPTH_CNT);
    assign do_pop      = pop && !empty;
    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_push     = push && (!full || do_pop);
    assign rd_next_idx = rd_ptr_q[PW-1:0] + 1'b1;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        head_d   = head_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                // With one entry left the new head is the word arriving now, not yet in storage.
                if (count == ONE_CNT) begin
                    if (do_push) begin
                        head_d = push_entry;
                    end
                end else begin
                    head_d = mem_q[rd_next_idx];
                end
            end else if (do_push && empty) begin
                head_d = push_entry;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            head_q   <= head_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push && !flush) begin
            mem_q[wr_ptr_q[PW-1:0]] <= push_entry;
        end
    end

    assign head_pc    = head_q.pc;
    assign head_instr = head_q.instr;

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction prefetch unit: one outstanding handshaked fetch at a time, results buffered
// in a small FIFO for decode, with redirect flushing both buffered and in-flight words.
module ifu_prefetch
    import cpu_pkg::*;
#(
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                   clock,
    input  logic                   reset,
    output logic                   mem_req,
    output logic [ADDR_W-1:0]      mem_addr,
    input  logic                   mem_gnt,
    input  logic                   mem_rvalid,
    input  logic [INSTR_W-1:0]     mem_rdata,
    input  logic                   redirect,
    input  logic [ADDR_W-1:0]      redirect_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INSTR_W-1:0]     out_instr,
    output logic [ADDR_W-1:0]      out_pc,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int unsigned     CW        = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]   LAST_SLOT = CW'(DEPTH - 1);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic              discard_q, discard_d;
    logic [ADDR_W-1:0] redir_pc;
    logic              push, pop;
    logic              fifo_empty, fifo_full;
    logic              full_after_push;

    assign redir_pc        = align_word(redirect_pc);
    assign pop             = out_valid && out_ready;
    assign full_after_push = (fifo_count == LAST_SLOT) && !pop;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        pend_pc_d  = pend_pc_q;
        req_pc_d   = req_pc_q;
        discard_d  = discard_q;
        push       = 1'b0;
        if (redirect) begin
            fetch_pc_d = redir_pc;
        end
        unique case (state_q)
            IDLE: begin
                if (redirect) begin
                    state_d   = REQ;
                    pend_pc_d = redir_pc;
                end else if (!fifo_full) begin
                    state_d   = REQ;
                    pend_pc_d = fetch_pc_q;
                end
            end
            REQ: begin
                // The pending address stays on the bus until granted; a redirect only
                // marks the eventual response as stale.
                if (redirect) begin
                    discard_d = 1'b1;
                end
                if (mem_gnt) begin
                    state_d  = WAIT;
                    req_pc_d = pend_pc_q;
                    if (!redirect && !discard_q) begin
                        fetch_pc_d = pend_pc_q + PC_STEP;
                    end
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    discard_d = 1'b0;
                    push      = !discard_q && !redirect;
                    if (redirect) begin
                        state_d   = REQ;
                        pend_pc_d = redir_pc;
                    end else if (push && full_after_push) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = REQ;
                        pend_pc_d = fetch_pc_q;
                    end
                end else if (redirect) begin
                    discard_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            pend_pc_q  <= RESET_PC;
            req_pc_q   <= RESET_PC;
            discard_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pend_pc_q  <= pend_pc_d;
            req_pc_q   <= req_pc_d;
            discard_q  <= discard_d;
        end
    end

    assign mem_req   = (state_q == REQ);
    assign mem_addr  = mem_req ? pend_pc_q : fetch_pc_q;
    assign out_valid = !fifo_empty;

    ifu_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .flush      (redirect),
        .push       (push),
        .pop        (pop),
        .push_pc    (req_pc_q),
        .push_instr (mem_rdata),
        .head_pc    (out_pc),
        .head_instr (out_instr),
        .empty      (fifo_empty),
        .full       (fifo_full),
        .count      (fifo_count)
    );

endmodule

// File: tb/tb_ifu_prefetch.sv
// Scoreboard bench for ifu_prefetch: directed scenarios queue expected fetch addresses and
// decode-side {pc, instr} pairs; monitors pop and compare whenever the DUT presents them.
module tb_ifu_prefetch;
    import cpu_pkg::*;

    logic        clock, reset;
    logic        mem_req, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_rdata;
    logic        redirect, out_valid, out_ready;
    logic [31:0] redirect_pc, out_instr, out_pc;
    logic [2:0]  fifo_count;

    logic        hi_reset, hi_req, hi_gnt, hi_rvalid, hi_out_valid;
    logic [31:0] hi_addr, hi_rdata, hi_out_instr, hi_out_pc, hi_lat;
    logic [2:0]  hi_count;

    int total, bad;
    int gnt_delay, resp_delay, budget, hi_budget;
    logic [31:0] exp_addr_q[$];
    logic [63:0] exp_out_q[$];
    logic [31:0] hi_addr_q[$];
    logic [31:0] hi_pc_q[$];

    ifu_prefetch #(.DEPTH(4), .RESET_PC(32'h0000_0000)) u_dut (
        .clock(clock), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc), .out_valid(out_valid),
        .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc), .fifo_count(fifo_count)
    );

    ifu_prefetch #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_hi (
        .clock(clock), .reset(hi_reset), .mem_req(hi_req), .mem_addr(hi_addr),
        .mem_gnt(hi_gnt), .mem_rvalid(hi_rvalid), .mem_rdata(hi_rdata),
        .redirect(1'b0), .redirect_pc(32'h0), .out_valid(hi_out_valid),
        .out_ready(1'b1), .out_instr(hi_out_instr), .out_pc(hi_out_pc), .fifo_count(hi_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    // Memory image: instruction word derived from its address.
    function automatic logic [31:0] img(input logic [31:0] a);
        return {a[15:0] ^ 16'hC0DE, a[31:16] ^ 16'h1234};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        total++;
        bad++;
        $display("FAIL %s: got unexpected %h expected nothing", name, act);
    endtask

    // Main memory model: grant after gnt_delay held cycles, data resp_delay cycles later.
    initial begin
        bit          resp_pend;
        int          hold_cnt, resp_cnt;
        logic [31:0] resp_addr;
        resp_pend = 0; hold_cnt = 0; resp_cnt = 0; resp_addr = '0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                mem_gnt = 0; mem_rvalid = 0; resp_pend = 0; hold_cnt = 0;
            end else begin
                mem_rvalid = 0;
                if (resp_pend) begin
                    if (resp_cnt <= 1) begin
                        mem_rvalid = 1; mem_rdata = img(resp_addr); resp_pend = 0;
                    end else begin
                        resp_cnt--;
                    end
                end
                mem_gnt = 0;
                if (mem_req) begin
                    if (hold_cnt >= gnt_delay && budget > 0) begin
                        mem_gnt = 1; budget--; hold_cnt = 0;
                        resp_pend = 1; resp_cnt = resp_delay; resp_addr = mem_addr;
                    end else begin
                        hold_cnt++;
                    end
                end
            end
        end
    end

    // Memory for the high-reset-address instance: always grants, 1-cycle response.
    initial begin
        hi_gnt = 0; hi_rvalid = 0; hi_rdata = '0; hi_lat = '0;
        forever begin
            @(negedge clock);
            if (!hi_reset) begin
                hi_gnt = 0; hi_rvalid = 0;
            end else begin
                hi_rvalid = hi_gnt;
                hi_rdata  = ~hi_lat;
                hi_gnt    = hi_req && hi_budget > 0;
                if (hi_gnt) begin
                    hi_budget--; hi_lat = hi_addr;
                end
            end
        end
    end

    // Monitor: fetch addresses, request stability, decode-side output pairs.
    initial begin
        bit          prev_hold;
        logic [31:0] prev_addr;
        logic [63:0] e;
        prev_hold = 0; prev_addr = '0;
        forever begin
            @(negedge clock);
            #2;
            if (!reset) begin
                prev_hold = 0;
            end else begin
                if (mem_req && mem_gnt) begin
                    if (exp_addr_q.size() == 0) unexpected("fetch_addr", mem_addr);
                    else check("fetch_addr", mem_addr, exp_addr_q.pop_front());
                end
                if (prev_hold) begin
                    check("req_held", 32'(mem_req), 32'd1);
                    check("addr_held", mem_addr, prev_addr);
                end
                prev_hold = mem_req && !mem_gnt;
                prev_addr = mem_addr;
                if (out_valid && out_ready) begin
                    if (exp_out_q.size() == 0) begin
                        unexpected("out_pc", out_pc);
                    end else begin
                        e = exp_out_q.pop_front();
                        check("out_pc", out_pc, e[63:32]);
                        check("out_instr", out_instr, e[31:0]);
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            #2;
            if (hi_reset) begin
                if (hi_req && hi_gnt) begin
                    if (hi_addr_q.size() == 0) unexpected("hi_fetch_addr", hi_addr);
                    else check("hi_fetch_addr", hi_addr, hi_addr_q.pop_front());
                end
                if (hi_out_valid) begin
                    if (hi_pc_q.size() == 0) unexpected("hi_out_pc", hi_out_pc);
                    else check("hi_out_pc", hi_out_pc, hi_pc_q.pop_front());
                end
            end
        end
    end

    task automatic expect_seq(input logic [31:0] base, input int n, input bit outs);
        for (int i = 0; i < n; i++) begin
            exp_addr_q.push_back(base + 32'(i * 4));
            if (outs) exp_out_q.push_back({base + 32'(i * 4), img(base + 32'(i * 4))});
        end
    endtask

    task automatic expect_out(input logic [31:0] pc);
        exp_out_q.push_back({pc, img(pc)});
    endtask

    task automatic apply_reset();
        @(posedge clock); #1;
        reset = 0; redirect = 0; out_ready = 0;
        @(posedge clock); #1;
        exp_addr_q.delete(); exp_out_q.delete();
        gnt_delay = 0; resp_delay = 1; budget = 0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_addr_q.size() != 0 || exp_out_q.size() != 0) && n < 200) begin
            @(posedge clock); n++;
        end
        total++;
        if (n >= 200) begin
            bad++;
            $display("FAIL %s: drain timeout, got %0d fetches %0d outputs outstanding expected 0",
                     name, exp_addr_q.size(), exp_out_q.size());
        end
        repeat (6) @(posedge clock);
    endtask

    task automatic wait_grant(input string name);
        int n;
        bit seen;
        n = 0; seen = 0;
        while (!seen && n < 50) begin
            @(negedge clock); #3;
            if (mem_req && mem_gnt) seen = 1;
            n++;
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL %s: got no grant in %0d cycles expected one", name, n);
        end
        @(posedge clock); #1;
    endtask

    initial begin
        total = 0; bad = 0;
        gnt_delay = 0; resp_delay = 1; budget = 0; hi_budget = 4;
        redirect = 0; redirect_pc = '0; out_ready = 0;
        reset = 1; hi_reset = 1;
        #2;
        reset = 0; hi_reset = 0;
        repeat (2) @(posedge clock); #1;

        // Reset values
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_fifo_count", 32'(fifo_count), 32'd0);
        check("rst_hi_mem_addr", hi_addr, 32'hFFFF_FFF8);

        // Wrap-around instance runs alongside the first scenario.
        hi_addr_q = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        hi_pc_q   = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        hi_reset  = 1;

        // 1-cycle memory, decode always ready.
        out_ready = 1; budget = 6;
        expect_seq(32'h0, 6, 1);
        reset = 1;
        @(posedge clock); #1;
        check("t1_req_cycle1", 32'(mem_req), 32'd1);
        check("t1_valid_cycle1", 32'(out_valid), 32'd0);
        @(posedge clock); #1;
        check("t1_valid_cycle2", 32'(out_valid), 32'd0);
        @(posedge clock); #1;
        check("t1_valid_cycle3", 32'(out_valid), 32'd1);
        check("t1_pc_cycle3", out_pc, 32'h0);
        check("t1_instr_cycle3", out_instr, 32'hC0DE_1234);
        wait_drain("t1_stream");

        // Decode stalled: exactly DEPTH fetches, then resume.
        apply_reset();
        budget = 8;
        expect_seq(32'h0, 8, 1);
        reset = 1;
        repeat (20) @(posedge clock); #1;
        check("t2_fifo_full", 32'(fifo_count), 32'd4);
        check("t2_req_dropped", 32'(mem_req), 32'd0);
        check("t2_fetches_left", 32'(exp_addr_q.size()), 32'd4);
        check("t2_head_pc", out_pc, 32'h0);
        out_ready = 1;
        wait_drain("t2_resume");

        // Slow grant: request must hold for 3 cycles each time.
        apply_reset();
        gnt_delay = 3; budget = 4; out_ready = 1;
        expect_seq(32'h0, 4, 1);
        reset = 1;
        wait_drain("t3_slow_gnt");

        // Redirect while waiting for data.
        apply_reset();
        resp_delay = 3; budget = 3; out_ready = 1;
        exp_addr_q = '{32'h0, 32'h100, 32'h104};
        expect_out(32'h100);
        expect_out(32'h104);
        reset = 1;
        wait_grant("t4_grant");
        redirect = 1; redirect_pc = 32'h0000_0103;
        @(posedge clock); #1;
        redirect = 0;
        check("t4_flushed", 32'(fifo_count), 32'd0);
        check("t4_still_wait", 32'(mem_req), 32'd0);
        wait_drain("t4_redirect_wait");

        // Redirect coinciding with rvalid and a decode transfer.
        apply_reset();
        budget = 5;
        exp_addr_q = '{32'h0, 32'h4, 32'h8, 32'h200, 32'h204};
        expect_out(32'h0);
        expect_out(32'h200);
        expect_out(32'h204);
        reset = 1;
        wait_grant("t5_grant0");
        wait_grant("t5_grant1");
        wait_grant("t5_grant2");
        check("t5_pre_count", 32'(fifo_count), 32'd2);
        redirect = 1; redirect_pc = 32'h0000_0200; out_ready = 1;
        @(posedge clock); #1;
        redirect = 0;
        check("t5_flushed", 32'(fifo_count), 32'd0);
        wait_drain("t5_redirect_rvalid");

        // Asynchronous reset while a fetch is outstanding.
        apply_reset();
        resp_delay = 4; budget = 2;
        exp_addr_q = '{32'h0, 32'h4};
        reset = 1;
        wait_grant("t6_grant0");
        wait_grant("t6_grant1");
        check("t6_pre_valid", 32'(out_valid), 32'd1);
        check("t6_pre_addr", mem_addr, 32'h8);
        #2;
        reset = 0;
        #1;
        check("t6_async_req", 32'(mem_req), 32'd0);
        check("t6_async_valid", 32'(out_valid), 32'd0);
        check("t6_async_count", 32'(fifo_count), 32'd0);
        check("t6_async_addr", mem_addr, 32'h0);

        check("hi_fetch_left", 32'(hi_addr_q.size()), 32'd0);
        check("hi_out_left", 32'(hi_pc_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
